// File: rtl/store_queue.sv
// Purpose: in-order store buffer between the never-stalling core store port and the data memory / MMIO bus.
// Latency: a store sampled at edge N is presented at the head after edge N (no same-cycle passthrough).
// Backpressure: none towards the core; stores arriving on a full queue with no pop are dropped and counted.
module store_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_we,
    input  logic [AW-1:0]              mem_addr,
    input  logic [DW-1:0]              mem_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [AW-1:0]              out_addr,
    output logic [DW-1:0]              out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt,
    input  logic                       ovf_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t          entries [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            pop;
    logic            push;
    logic            drop;
    entry_t          head;

    // Status flags come only from the registered occupancy, never from mem_we.
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = !empty;

    assign pop  = out_valid & out_ready;
    assign push = mem_we & (!full | pop);
    assign drop = mem_we & full & !pop;

    // Head is read from storage indexed by the registered read pointer; forced to zero while empty.
    always_comb begin
        head     = entries[rd_ptr];
        out_addr = '0;
        out_data = '0;
        if (!empty) begin
            out_addr = head.addr;
            out_data = head.data;
        end
    end

    // Entry storage: written on accepted pushes only, deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= '{addr: mem_addr, data: mem_data};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Loss reporting: a drop in the same cycle as a clear wins and restarts the tally at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_store_queue.sv
// Purpose: self-checking bench for store_queue against a queue-based reference model.
// Latency: model expects a store on the head one edge after it is sampled.
// Backpressure: out_ready is driven directly; drops are predicted from model occupancy.
module tb_store_queue;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        ovf_clr;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    logic [63:0] q[$];
    logic        m_ovf;
    int          m_drop;

    store_queue #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("count", 64'(count), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_addr", 64'(out_addr), 64'(q[0][63:32]));
            chk("out_data", 64'(out_data), 64'(q[0][31:0]));
        end else begin
            chk("out_addr_idle", 64'(out_addr), 64'd0);
            chk("out_data_idle", 64'(out_data), 64'd0);
        end
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    endtask

    // One clock cycle: drive at the negedge, predict, update model at posedge, check at next negedge.
    task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic rdy, input logic clr);
        bit m_full, m_pop, m_push, m_dropped;
        mem_we    = we;
        mem_addr  = a;
        mem_data  = d;
        out_ready = rdy;
        ovf_clr   = clr;
        m_full    = (q.size() == DEPTH);
        m_pop     = (q.size() != 0) && rdy;
        m_push    = we && (!m_full || m_pop);
        m_dropped = we && m_full && !m_pop;
        @(posedge clk);
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back({a, d});
        if (m_dropped) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, $urandom, $urandom, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 2 && q.size() != 0; k++) idle(1'b1);
        chk("drained", 64'(count), 64'd0);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    initial begin
        int pushed;
        logic we_r, rdy_r;

        rst = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_data = '0;
        out_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // idle after reset
        for (int i = 0; i < 5; i++) idle(1'b0);

        // single store with ready held high: visible right after the sampling edge
        cycle(1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_addr", 64'(out_addr), 64'h10);
        chk("single_data", 64'(out_data), 64'hDEADBEEF);
        idle(1'b1);
        chk("single_cnt0", 64'(count), 64'd0);

        // ten stores with no ready: last two dropped
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
            if (i == 7) chk("full_after_8", 64'(full), 64'd1);
        end
        chk("ovf_after_10", 64'(overflow), 64'd1);
        chk("drop_after_10", 64'(drop_cnt), 64'd2);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", 64'(out_data), 64'h100 + 64'(i));
            idle(1'b1);
        end
        chk("drain_empty", 64'(empty), 64'd1);

        // clear, refill, then push and pop together on a full queue
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("clr_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h200 + 32'(i), 32'h300 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h2AA, 32'h3AA, 1'b1, 1'b0);
        chk("full_pp_cnt", 64'(count), 64'd8);
        chk("full_pp_drop", 64'(drop_cnt), 64'd0);
        for (int i = 1; i < 8; i++) begin
            chk("full_pp_order", 64'(out_data), 64'h300 + 64'(i));
            idle(1'b1);
        end
        chk("full_pp_last", 64'(out_data), 64'h3AA);
        drain();

        // random valid/ready, no drops
        pushed = 0;
        for (int it = 0; it < 2000 && pushed < 40; it++) begin
            rdy_r = 1'($urandom_range(0, 1));
            we_r  = 1'($urandom_range(0, 1));
            if (q.size() == DEPTH && !rdy_r) we_r = 1'b0;
            cycle(we_r, $urandom, $urandom, rdy_r, 1'b0);
            if (we_r) pushed++;
        end
        chk("rand_pushed", 64'(pushed), 64'd40);
        chk("rand_no_ovf", 64'(overflow), 64'd0);
        drain();

        // five entries with overflow set, then async reset mid-cycle
        for (int i = 0; i < 9; i++) cycle(1'b1, 32'h400 + 32'(i), 32'h500 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("pre_rst_cnt", 64'(count), 64'd5);
        chk("pre_rst_ovf", 64'(overflow), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1);

        // ovf_clr coincident with a drop: drop wins
        for (int i = 0; i < 9; i++) cycle(1'b1, 32'h600 + 32'(i), 32'h700 + 32'(i), 1'b0, 1'b0);
        chk("pre_clr_drop", 64'(drop_cnt), 64'd1);
        cycle(1'b1, 32'h6FF, 32'h7FF, 1'b0, 1'b0);
        chk("pre_clr_drop2", 64'(drop_cnt), 64'd2);
        cycle(1'b1, 32'h6EE, 32'h7EE, 1'b0, 1'b1);
        chk("clr_drop_ovf", 64'(overflow), 64'd1);
        chk("clr_drop_cnt", 64'(drop_cnt), 64'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("clr_only", 64'(drop_cnt), 64'd0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
